// File: rtl/sort16_chunk_ctrl_pkg.sv
// Shared types for the 16-wide range sorter front/back-end controller.
package sort16_chunk_ctrl_pkg;

  localparam int unsigned PAIR_W = 128;
  localparam int unsigned SLOTS  = 16;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CNT_W  = 5;

  typedef struct packed {
    logic [63:0] start;
    logic [63:0] stop;
  } tuple_pair_t;

  // Sentinel that sorts above every real pair.
  localparam tuple_pair_t PAD_PAIR = '1;

  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic             last;
  } chunk_meta_t;

  localparam int unsigned META_W = $bits(chunk_meta_t);

  typedef enum logic [1:0] {
    FILL,
    WAIT_CREDIT,
    ISSUE_A,
    ISSUE_B
  } sort_ctrl_state_t;

endpackage

// File: rtl/sort16_chunk_ctrl_fifo.sv
// Synchronous FIFO with full/empty; a push while full is dropped unless a pop
// happens in the same cycle.
module chunk_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sort16_chunk_ctrl.sv
// Packs range pairs into padded 16-slot chunks, issues each as a two-beat burst
// to the bitonic sorter and buffers sorted chunks under credit flow control.
module sort16_chunk_ctrl
  import sort16_chunk_ctrl_pkg::*;
#(
  parameter int unsigned PAIR_W    = sort16_chunk_ctrl_pkg::PAIR_W,
  parameter int unsigned OUT_DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PAIR_W-1:0]      in_pair,
  input  logic                   in_last,
  output logic                   sort_valid_in,
  output logic [16*PAIR_W-1:0]   sort_pairs_flat,
  input  logic                   sort_valid_out,
  input  logic [16*PAIR_W-1:0]   sort_pairs_out_flat,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [16*PAIR_W-1:0]   out_pairs_flat,
  output logic [4:0]             out_count,
  output logic                   out_last,
  output logic                   busy,
  output logic                   err_overflow
);

  localparam int unsigned CRED_W = $clog2(OUT_DEPTH + 1);

  sort_ctrl_state_t             state, state_next;
  logic [IDX_W-1:0]             idx, idx_next;
  logic [CRED_W-1:0]            credits, credits_next;
  logic [CNT_W-1:0]             cnt, cnt_next;
  logic                         last_q, last_next;
  logic [SLOTS-1:0][PAIR_W-1:0] slots;
  logic                         accept, load_slot, clear_slots, issue, pop, credit_ok;
  logic                         data_empty, data_full, meta_empty, meta_full;
  chunk_meta_t                  meta_head, meta_tail;

  assign pop       = out_valid && out_ready;
  assign accept    = (state == FILL) && in_valid && in_ready;
  // Meta room is implied by a credit; kept explicit so the two FIFOs cannot skew.
  assign credit_ok = (credits != '0) && !meta_full;
  assign meta_tail = '{count: cnt, last: last_q};

  always_comb begin
    state_next  = state;
    idx_next    = idx;
    cnt_next    = cnt;
    last_next   = last_q;
    load_slot   = 1'b0;
    clear_slots = 1'b0;
    issue       = 1'b0;
    unique case (state)
      FILL: begin
        if (accept) begin
          load_slot = 1'b1;
          idx_next  = idx + IDX_W'(1);
          if (idx == IDX_W'(SLOTS - 1) || in_last) begin
            cnt_next   = CNT_W'(idx) + CNT_W'(1);
            last_next  = in_last;
            state_next = credit_ok ? ISSUE_A : WAIT_CREDIT;
          end
        end
      end
      WAIT_CREDIT: if (credit_ok || pop) state_next = ISSUE_A;
      ISSUE_A: begin
        issue      = 1'b1;
        state_next = ISSUE_B;
      end
      ISSUE_B: begin
        clear_slots = 1'b1;
        idx_next    = '0;
        state_next  = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  always_comb begin
    credits_next = credits;
    if (issue && !pop)
      credits_next = credits - CRED_W'(1);
    else if (pop && !issue && credits != CRED_W'(OUT_DEPTH))
      credits_next = credits + CRED_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= FILL;
      idx           <= '0;
      credits       <= CRED_W'(OUT_DEPTH);
      cnt           <= '0;
      last_q        <= 1'b0;
      in_ready      <= 1'b1;
      sort_valid_in <= 1'b0;
      busy          <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      state         <= state_next;
      idx           <= idx_next;
      credits       <= credits_next;
      cnt           <= cnt_next;
      last_q        <= last_next;
      in_ready      <= (state_next == FILL);
      sort_valid_in <= (state_next == ISSUE_A) || (state_next == ISSUE_B);
      busy          <= (state_next != FILL) || (idx_next != '0) ||
                       (credits_next != CRED_W'(OUT_DEPTH));
      err_overflow  <= err_overflow || (sort_valid_out && data_full && !pop);
    end
  end

  // Slot registers feed the sorter directly and stay stable across the burst.
  always_ff @(posedge clock) begin
    if (reset || clear_slots) begin
      for (int i = 0; i < int'(SLOTS); i++) slots[i] <= PAIR_W'(PAD_PAIR);
    end else if (load_slot) begin
      slots[idx] <= in_pair;
    end
  end

  assign sort_pairs_flat = slots;

  chunk_fifo #(.WIDTH(16 * PAIR_W), .DEPTH(OUT_DEPTH)) u_data_fifo (
    .clock (clock),
    .reset (reset),
    .push  (sort_valid_out),
    .pop   (pop),
    .din   (sort_pairs_out_flat),
    .dout  (out_pairs_flat),
    .full  (data_full),
    .empty (data_empty)
  );

  chunk_fifo #(.WIDTH(META_W), .DEPTH(OUT_DEPTH)) u_meta_fifo (
    .clock (clock),
    .reset (reset),
    .push  (issue),
    .pop   (pop),
    .din   (meta_tail),
    .dout  (meta_head),
    .full  (meta_full),
    .empty (meta_empty)
  );

  assign out_valid = !data_empty;
  assign out_count = (out_valid && !meta_empty) ? meta_head.count : '0;
  assign out_last  = out_valid && !meta_empty && meta_head.last;

endmodule

// File: tb/tb_sort16_chunk_ctrl.sv
// Bench for sort16_chunk_ctrl: behavioural sorter, scoreboarded consumer and
// directed flow-control, reset and overflow scenarios.
module tb_sort16_chunk_ctrl;

  localparam int unsigned PW     = 128;
  localparam int unsigned NS     = 16;
  localparam int          LAT    = 3;
  localparam int          PERIOD = 10;

  typedef logic [PW-1:0]    pair_t;
  typedef logic [NS*PW-1:0] flat_t;
  typedef struct { flat_t data; longint due; } pend_t;
  typedef struct { flat_t data; int cnt; bit last; } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_ready, in_last = 1'b0;
  pair_t       in_pair = '0;
  logic        sort_valid_in, sort_valid_out = 1'b0;
  flat_t       sort_pairs_flat, sort_pairs_out_flat = '0, out_pairs_flat;
  logic        out_valid, out_ready = 1'b0, out_last, busy, err_overflow;
  logic [4:0]  out_count;

  int     vectors = 0;
  int     fails = 0;
  int     ready_mode = 0;
  int     outs = 0;
  int     n_bursts = 0;
  bit     force_req = 1'b0;
  time    t_acc, t_acc0, t_issue;
  exp_t   expq[$];
  pair_t  cur[$];
  pend_t  pend[$];

  always #(PERIOD / 2) clock = ~clock;

  sort16_chunk_ctrl #(.PAIR_W(PW), .OUT_DEPTH(2)) dut (
    .clock               (clock),
    .reset               (reset),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_pair             (in_pair),
    .in_last             (in_last),
    .sort_valid_in       (sort_valid_in),
    .sort_pairs_flat     (sort_pairs_flat),
    .sort_valid_out      (sort_valid_out),
    .sort_pairs_out_flat (sort_pairs_out_flat),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_pairs_flat      (out_pairs_flat),
    .out_count           (out_count),
    .out_last            (out_last),
    .busy                (busy),
    .err_overflow        (err_overflow)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic flat_t sort_flat(input flat_t f);
    pair_t a[NS];
    pair_t t;
    flat_t r;
    for (int i = 0; i < NS; i++) a[i] = f[i*PW +: PW];
    for (int i = 1; i < NS; i++)
      for (int j = i; j > 0 && a[j-1] > a[j]; j--) begin
        t = a[j]; a[j] = a[j-1]; a[j-1] = t;
      end
    for (int i = 0; i < NS; i++) r[i*PW +: PW] = a[i];
    return r;
  endfunction

  // Scoreboard: close a chunk at 16 pairs or on the last pair of a set.
  task automatic model_pair(input pair_t p, input bit last);
    exp_t e;
    flat_t f;
    cur.push_back(p);
    if (cur.size() == NS || last) begin
      f = '1;
      foreach (cur[i]) f[i*PW +: PW] = cur[i];
      e.data = sort_flat(f);
      e.cnt  = cur.size();
      e.last = last;
      expq.push_back(e);
      cur.delete();
    end
  endtask

  // Called at a negedge; returns at the negedge following the handshake edge.
  task automatic send_pair(input pair_t p, input bit last, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) @(negedge clock);
    in_valid = 1'b1;
    in_pair  = p;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 5000) begin
      @(negedge clock);
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    t_acc = $time;
    @(negedge clock);
    in_valid = 1'b0;
    in_last  = 1'b0;
    model_pair(p, last);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy || expq.size() != 0 || pend.size() != 0) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk(tag, (!busy && expq.size() == 0), 1);
  endtask

  function automatic pair_t rnd_pair();
    return {32'h0, $urandom, $urandom, $urandom};
  endfunction

  // Sorter model: two-beat burst in, sorted chunk out LAT cycles after beat two.
  bit    half = 1'b0;
  int    run = 0;
  longint cyc = 0;
  flat_t beat_a;
  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      half = 1'b0;
      run = 0;
      pend.delete();
      sort_valid_out = 1'b0;
    end else begin
      sort_valid_out = 1'b0;
      if (force_req) begin
        sort_valid_out      = 1'b1;
        sort_pairs_out_flat = '0;
      end else if (pend.size() > 0 && pend[0].due <= cyc) begin
        sort_valid_out      = 1'b1;
        sort_pairs_out_flat = pend[0].data;
        void'(pend.pop_front());
      end
      if (sort_valid_in) begin
        run++;
        if (run == 1) t_issue = $time;
        if (half) begin
          chk("beat_hold", (sort_pairs_flat === beat_a), 1);
          pend.push_back('{data: sort_flat(sort_pairs_flat), due: cyc + LAT});
          n_bursts++;
        end else begin
          beat_a = sort_pairs_flat;
        end
        half = ~half;
      end else if (run != 0) begin
        chk("burst_len", run, 2);
        run = 0;
      end
    end
  end

  // Consumer: drives out_ready and compares each accepted chunk.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      out_ready = 1'b0;
    end else begin
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid && out_ready) begin
        chk("expect_avail", (expq.size() > 0), 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          for (int i = 0; i < NS; i++)
            chk($sformatf("slot%0d", i), out_pairs_flat[i*PW +: PW], e.data[i*PW +: PW]);
          chk("out_count", out_count, e.cnt);
          chk("out_last", out_last, e.last);
        end
        outs++;
      end
    end
  end

  initial begin
    #(PERIOD * 50000);
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int len;
    bit lst;
    repeat (3) @(negedge clock);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sort_valid_in", sort_valid_in, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_overflow, 0);
    chk("rst_pad_slot0", sort_pairs_flat[PW-1:0], {PW{1'b1}});
    reset = 1'b0;
    @(negedge clock);

    // Full chunk, descending starts, back to back.
    ready_mode = 1;
    for (int i = 0; i < 16; i++) begin
      send_pair({64'(16 - i), 64'(100 + i)}, i == 15, 0);
      if (i == 0) t_acc0 = t_acc;
    end
    @(negedge clock);
    chk("issue_latency", 128'(t_issue - t_acc0), 128'(16 * PERIOD));
    wait_idle("idle_t1");

    // Short padded chunk.
    send_pair({64'd9, 64'd90}, 0, 0);
    send_pair({64'd7, 64'd70}, 0, 1);
    send_pair({64'd3, 64'd30}, 0, 0);
    send_pair({64'd8, 64'd80}, 0, 2);
    send_pair({64'd1, 64'd10}, 1, 0);
    wait_idle("idle_t2");

    // Credit exhaustion with a stalled consumer.
    ready_mode = 0;
    base = n_bursts;
    for (int i = 0; i < 48; i++) send_pair(rnd_pair(), i == 47, 0);
    chk("wait_in_ready", in_ready, 0);
    chk("wait_busy", busy, 1);
    repeat (6) @(negedge clock);
    chk("wait_hold_in_ready", in_ready, 0);
    chk("wait_sort_valid_in", sort_valid_in, 0);
    chk("wait_two_issues", n_bursts - base, 2);
    chk("wait_out_valid", out_valid, 1);
    ready_mode = 1;
    wait_idle("idle_t3");
    chk("third_issue", n_bursts - base, 3);
    chk("no_overflow_t3", err_overflow, 0);

    // Random gaps and consumer stalls over 40 chunks.
    ready_mode = 2;
    base = outs;
    for (int c = 0; c < 40; c++) begin
      len = $urandom_range(1, 16);
      lst = (len < 16) || ($urandom_range(0, 2) == 0);
      for (int k = 0; k < len; k++)
        send_pair(rnd_pair(), lst && (k == len - 1), $urandom_range(0, 2));
    end
    wait_idle("idle_t4");
    chk("t4_chunk_total", outs - base, 40);
    chk("t4_busy", busy, 0);
    chk("t4_in_ready", in_ready, 1);
    chk("no_overflow_t4", err_overflow, 0);

    // Reset in ISSUE_A with one chunk buffered.
    ready_mode = 0;
    for (int i = 0; i < 32; i++) send_pair(rnd_pair(), 0, 0);
    chk("pre_rst_issue", sort_valid_in, 1);
    chk("pre_rst_buffered", out_valid, 1);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sort_valid_in", sort_valid_in, 0);
    chk("mid_rst_out_count", out_count, 0);
    @(negedge clock);
    reset = 1'b0;
    expq.delete();
    cur.delete();
    repeat (4) @(negedge clock);
    chk("post_rst_sort_valid_in", sort_valid_in, 0);
    chk("post_rst_out_valid", out_valid, 0);

    // Sorter output while the data FIFO is full.
    send_pair({64'd5, 64'd6}, 1, 0);
    send_pair({64'd2, 64'd3}, 1, 0);
    repeat (10) @(negedge clock);
    chk("ovf_fifo_full", out_valid, 1);
    chk("ovf_before", err_overflow, 0);
    @(posedge clock);
    force_req = 1'b1;
    @(posedge clock);
    force_req = 1'b0;
    @(negedge clock);
    chk("ovf_set", err_overflow, 1);
    repeat (3) @(negedge clock);
    chk("ovf_sticky", err_overflow, 1);
    ready_mode = 1;
    wait_idle("idle_t6");
    chk("ovf_sticky_drain", err_overflow, 1);
    ready_mode = 0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("ovf_cleared", err_overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
